stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Controller that sequences the 3-digit BCD count shown on the 4-digit seven-segment display.
//  Replaces the derived-clock scheme: everything runs on the board clk, and an internal
//  prescaler issues a one-cycle count-enable tick.
//  Start/stop and clear buttons drive a run/pause/overflow FSM.
//  Digits and blank flags feed hex_to_sseg/disp_mux at top level.
// PARAMETERS
//  TICK_DIV  50_000_000  clk cycles per count increment (>=2)
//  WRAP      1           1: 999 wraps to 000 with ovf pulse; 0: saturate at 999, enter OVF
//  BLANK_LZ  1           1: report leading-zero blanking on blank[2:1]; 0: blank forced 0
// PORTS
//  clk         in   1  board clock; all logic on rising edge
//  reset       in   1  synchronous, active-low reset
//  btn_ss      in   1  start/stop button level (already debounced)
//  btn_clr     in   1  clear button level (already debounced)
//  bcd0        out  4  units digit, BCD 0-9
//  bcd1        out  4  tens digit, BCD 0-9
//  bcd2        out  4  hundreds digit, BCD 0-9
//  blank       out  3  per-digit blank request; blank[0] always 0
//  running     out  1  high while state==RUN
//  ovf         out  1  one-cycle pulse on 999->000 wrap (WRAP=1) or on entry to OVF (WRAP=0)
// BEHAVIOUR
//  Reset (reset==0 at clk edge):
//   - state=IDLE; digits=000; prescaler=0; ovf=0; running=0.
//   - Edge-detect regs set to 1, so a button held through reset does not fire.
//  Edge detect:
//   - ev_x = btn_x & ~prev_x; prev_x <= btn_x every cycle.
//   - The event acts on the same edge that samples it; its result is visible after that edge.
//  FSM: IDLE, RUN, PAUSE, OVF; all outputs are registered.
//   - ev_clr, from any state -> IDLE; digits=000; prescaler=0.
//   - ev_clr and ev_ss in the same cycle: clear wins, ev_ss dropped.
//   - ev_ss transitions: IDLE->RUN, RUN->PAUSE, PAUSE->RUN; ignored in OVF (only clear exits).
//  Prescaler:
//   - Counts 0..TICK_DIV-1 only in RUN.
//   - tick=1 in the cycle it equals TICK_DIV-1, then it returns to 0.
//   - Holds its value in PAUSE, so resume completes the partial period.
//   - Zeroed in IDLE/OVF.
//  Count on tick:
//   - BCD increment: bcd0 9->0 carries to bcd1; 9->0 carries to bcd2.
//   - At 999: WRAP=1 -> 000, ovf=1 for one cycle, stay RUN.
//   - At 999: WRAP=0 -> hold 999, state->OVF, ovf=1 for one cycle.
//   - A RUN->PAUSE event in the tick cycle: the increment still occurs; pause is taken the same edge.
//  Blank (BLANK_LZ=1):
//   - blank[2] = (bcd2==0).
//   - blank[1] = (bcd2==0 && bcd1==0).
//   - Computed from the registered digits; "000" shows a single "0".
//  Digits never leave 0-9; no state is reachable other than the four listed.
// STRUCTURE
//  stopwatch_defs.vh: state encodings (2-bit localparams), BCD_MAX=4'd9.
//  Sub-module bcd_digit (4-bit BCD reg, inputs clr/inc, outputs carry on 9->0), instanced x3,
//  chained by carry.
//  FSM, prescaler and edge detect stay inline in stopwatch_ctrl.
// TESTING (TICK_DIV=4 unless noted)
//  1. Reset held 3 cycles with btn_ss=1, then release -> IDLE, 000, running=0, no start event.
//  2. ev_ss in IDLE -> running=1; bcd0=1 after 4 clks, bcd0=2 after 8 clks.
//  3. Pause after 2 prescaler cycles, wait 20 clks, resume -> next increment exactly 2 clks after resume.
//  4. Preload to 998, WRAP=1: 8 clks -> 999 then 000, one-cycle ovf, still RUN.
//     Same with WRAP=0 -> 999 held, state OVF, ev_ss ignored.
//  5. ev_clr and ev_ss in the same cycle while RUN at 057 -> IDLE, 000, running=0.
//  6. Counts 0,7,10,100: blank=110,110,100,000; with BLANK_LZ=0, blank=000 always.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller.
//   state_t    : FSM state encoding (2 bits)
//   BCD_MAX    : largest legal BCD digit value
//   is_bcd_max : true when a digit holds BCD_MAX
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVF   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd_max(input logic [3:0] d);
    return d == BCD_MAX;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD digit of the stopwatch count.
// Ports:
//   i_clk    in  1  clock, rising edge
//   i_reset  in  1  synchronous active-low reset (digit -> 0)
//   i_clr    in  1  synchronous clear (digit -> 0), has priority over i_inc
//   i_inc    in  1  increment request
//   o_q      out 4  registered digit value, 0-9
//   o_carry  out 1  high when this increment rolls the digit from 9 to 0
module stopwatch_ctrl_bcd_digit
  import stopwatch_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [3:0] o_q,
  output logic       o_carry
);

  logic [3:0] r_q;
  logic       w_roll;

  // Values above 9 are treated as 9 so the digit can never drift out of range.
  assign w_roll  = (r_q >= BCD_MAX);
  assign o_carry = i_inc & ~i_clr & w_roll;
  assign o_q     = r_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_q <= 4'd0;
    end else if (i_clr) begin
      r_q <= 4'd0;
    end else if (i_inc) begin
      r_q <= w_roll ? 4'd0 : r_q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/overflow FSM, count-enable prescaler,
// button edge detection and a 3-digit BCD counter with leading-zero blanking.
// Parameters:
//   TICK_DIV  clk cycles per count increment (>= 2)
//   WRAP      1: 999 wraps to 000 with ovf pulse; 0: saturate at 999 and enter OVF
//   BLANK_LZ  1: report leading-zero blanking on blank[2:1]; 0: blank forced 0
// Ports:
//   i_clk      in  1  board clock
//   i_reset    in  1  synchronous active-low reset
//   i_btn_ss   in  1  start/stop button level (debounced)
//   i_btn_clr  in  1  clear button level (debounced)
//   o_bcd0     out 4  units digit
//   o_bcd1     out 4  tens digit
//   o_bcd2     out 4  hundreds digit
//   o_blank    out 3  per-digit blank request, bit 0 always 0
//   o_running  out 1  high while in RUN
//   o_ovf      out 1  one-cycle overflow pulse
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter bit WRAP     = 1'b1,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_ss,
  input  logic       i_btn_clr,
  output logic [3:0] o_bcd0,
  output logic [3:0] o_bcd1,
  output logic [3:0] o_bcd2,
  output logic [2:0] o_blank,
  output logic       o_running,
  output logic       o_ovf
);

  localparam int              PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  logic          r_prev_ss;
  logic          r_prev_clr;
  logic          r_ovf;

  logic          w_ev_ss;
  logic          w_ev_clr;
  logic          w_tick;
  logic          w_inc;
  logic          w_clr;
  logic          w_ovf_sat;
  logic          w_ovf_next;
  logic          w_at_max;
  logic          w_carry0;
  logic          w_carry1;
  logic          w_carry2;
  logic [3:0]    w_bcd0;
  logic [3:0]    w_bcd1;
  logic [3:0]    w_bcd2;

  // Rising-edge events; the prev registers reset high so a button held
  // through reset does not count as a press.
  assign w_ev_ss  = i_btn_ss  & ~r_prev_ss;
  assign w_ev_clr = i_btn_clr & ~r_prev_clr;

  assign w_tick   = (r_state == ST_RUN) && (r_presc == PRESC_LAST);
  assign w_at_max = is_bcd_max(w_bcd0) && is_bcd_max(w_bcd1) && is_bcd_max(w_bcd2);

  always_comb begin
    w_state_next = r_state;
    w_presc_next = r_presc;
    w_inc        = 1'b0;
    w_clr        = 1'b0;
    w_ovf_sat    = 1'b0;
    if (w_ev_clr) begin
      // Clear beats everything, including a simultaneous start/stop press.
      w_state_next = ST_IDLE;
      w_presc_next = '0;
      w_clr        = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_presc_next = '0;
          if (w_ev_ss) w_state_next = ST_RUN;
        end
        ST_RUN: begin
          w_presc_next = w_tick ? '0 : r_presc + PRESC_ONE;
          if (w_ev_ss) w_state_next = ST_PAUSE;
          // A pause in the tick cycle still takes the increment.
          if (w_tick) begin
            if (w_at_max && !WRAP) begin
              w_state_next = ST_OVF;
              w_ovf_sat    = 1'b1;
            end else begin
              w_inc = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          // Prescaler holds so the resumed period is completed, not restarted.
          if (w_ev_ss) w_state_next = ST_RUN;
        end
        ST_OVF: begin
          w_presc_next = '0;
        end
        default: begin
          w_state_next = ST_IDLE;
          w_presc_next = '0;
        end
      endcase
    end
  end

  // Carry out of the hundreds digit is exactly the 999 -> 000 wrap.
  assign w_ovf_next = w_ovf_sat | (WRAP & w_carry2);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_presc    <= '0;
      r_prev_ss  <= 1'b1;
      r_prev_clr <= 1'b1;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_presc    <= w_presc_next;
      r_prev_ss  <= i_btn_ss;
      r_prev_clr <= i_btn_clr;
      r_ovf      <= w_ovf_next;
    end
  end

  stopwatch_ctrl_bcd_digit u_digit0 (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_q     (w_bcd0),
    .o_carry (w_carry0)
  );

  stopwatch_ctrl_bcd_digit u_digit1 (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_clr),
    .i_inc   (w_carry0),
    .o_q     (w_bcd1),
    .o_carry (w_carry1)
  );

  stopwatch_ctrl_bcd_digit u_digit2 (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_clr),
    .i_inc   (w_carry1),
    .o_q     (w_bcd2),
    .o_carry (w_carry2)
  );

  // Blanking is decoded from the registered digits, so 000 shows a single 0.
  generate
    if (BLANK_LZ) begin : g_blank
      assign o_blank = {(w_bcd2 == 4'd0), (w_bcd2 == 4'd0) && (w_bcd1 == 4'd0), 1'b0};
    end else begin : g_no_blank
      assign o_blank = 3'b000;
    end
  endgenerate

  assign o_bcd0    = w_bcd0;
  assign o_bcd1    = w_bcd1;
  assign o_bcd2    = w_bcd2;
  assign o_running = (r_state == ST_RUN);
  assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl. Three instances share one stimulus:
//   A: WRAP=1 BLANK_LZ=1, B: WRAP=0 BLANK_LZ=1, C: WRAP=1 BLANK_LZ=0, all TICK_DIV=4.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ss  = 1'b0;
  logic clr = 1'b0;

  logic [3:0] a0, a1, a2, b0, b1, b2, c0, c1, c2;
  logic [2:0] a_blank, b_blank, c_blank;
  logic       a_run, b_run, c_run, a_ovf, b_ovf, c_ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(4), .WRAP(1'b1), .BLANK_LZ(1'b1)) u_a (
    .i_clk(clk), .i_reset(rst), .i_btn_ss(ss), .i_btn_clr(clr),
    .o_bcd0(a0), .o_bcd1(a1), .o_bcd2(a2), .o_blank(a_blank),
    .o_running(a_run), .o_ovf(a_ovf)
  );

  stopwatch_ctrl #(.TICK_DIV(4), .WRAP(1'b0), .BLANK_LZ(1'b1)) u_b (
    .i_clk(clk), .i_reset(rst), .i_btn_ss(ss), .i_btn_clr(clr),
    .o_bcd0(b0), .o_bcd1(b1), .o_bcd2(b2), .o_blank(b_blank),
    .o_running(b_run), .o_ovf(b_ovf)
  );

  stopwatch_ctrl #(.TICK_DIV(4), .WRAP(1'b1), .BLANK_LZ(1'b0)) u_c (
    .i_clk(clk), .i_reset(rst), .i_btn_ss(ss), .i_btn_clr(clr),
    .o_bcd0(c0), .o_bcd1(c1), .o_bcd2(c2), .o_blank(c_blank),
    .o_running(c_run), .o_ovf(c_ovf)
  );

  typedef struct {
    logic        ss;
    logic        clr;
    int          n;
    logic [11:0] bcd;
    logic        run;
    logic [2:0]  blank;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic c, input int n,
                     input logic [11:0] bcd, input logic run, input logic [2:0] blank);
    vec_t v;
    v.ss = s; v.clr = c; v.n = n; v.bcd = bcd; v.run = run; v.blank = blank;
    vecs.push_back(v);
  endtask

  initial begin
    // Vectors start right after reset release with btn_ss still held high.
    add(1, 0,    2, 12'h000, 0, 3'b110);  // held button does not start
    add(0, 0,    1, 12'h000, 0, 3'b110);
    add(1, 0,    1, 12'h000, 1, 3'b110);  // start
    add(0, 0,    3, 12'h000, 1, 3'b110);
    add(0, 0,    1, 12'h001, 1, 3'b110);  // 4 clks after start
    add(0, 0,    4, 12'h002, 1, 3'b110);  // 8 clks after start
    add(0, 0,    1, 12'h002, 1, 3'b110);  // prescaler 1
    add(1, 0,    1, 12'h002, 0, 3'b110);  // pause, prescaler held at 2
    add(0, 0,   20, 12'h002, 0, 3'b110);
    add(1, 0,    1, 12'h002, 1, 3'b110);  // resume
    add(0, 0,    1, 12'h002, 1, 3'b110);
    add(0, 0,    1, 12'h003, 1, 3'b110);  // increment 2 clks after resume
    add(0, 0,   16, 12'h007, 1, 3'b110);
    add(0, 0,   12, 12'h010, 1, 3'b100);
    add(0, 0,  188, 12'h057, 1, 3'b100);
    add(1, 1,    1, 12'h000, 0, 3'b110);  // clear + start/stop together: clear wins
    add(0, 0,    8, 12'h000, 0, 3'b110);  // dropped start does not linger
    add(1, 0,    1, 12'h000, 1, 3'b110);
    add(0, 0,  400, 12'h100, 1, 3'b000);
    add(0, 0, 3592, 12'h998, 1, 3'b000);

    // Reset held 3 cycles with start/stop pressed.
    rst = 1'b0; ss = 1'b1; clr = 1'b0;
    step(3);
    chk("reset_bcd", {a2, a1, a0}, 12'h000);
    chk("reset_run", a_run, 1'b0);
    chk("reset_ovf", a_ovf, 1'b0);
    chk("reset_blank", a_blank, 3'b110);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      ss  = vecs[i].ss;
      clr = vecs[i].clr;
      step(vecs[i].n);
      chk($sformatf("v%0d_a_bcd", i), {a2, a1, a0}, vecs[i].bcd);
      chk($sformatf("v%0d_a_run", i), a_run, vecs[i].run);
      chk($sformatf("v%0d_a_blank", i), a_blank, vecs[i].blank);
      chk($sformatf("v%0d_a_ovf", i), a_ovf, 1'b0);
      chk($sformatf("v%0d_b_bcd", i), {b2, b1, b0}, vecs[i].bcd);
      chk($sformatf("v%0d_b_run", i), b_run, vecs[i].run);
      chk($sformatf("v%0d_c_bcd", i), {c2, c1, c0}, vecs[i].bcd);
      chk($sformatf("v%0d_c_blank", i), c_blank, 3'b000);
    end

    // 998 -> 999 -> wrap (A) / saturate (B)
    ss = 1'b0; clr = 1'b0;
    step(4);
    chk("at999_a_bcd", {a2, a1, a0}, 12'h999);
    chk("at999_b_bcd", {b2, b1, b0}, 12'h999);
    chk("at999_a_ovf", a_ovf, 1'b0);
    chk("at999_b_run", b_run, 1'b1);
    step(3);
    chk("pre_wrap_a_bcd", {a2, a1, a0}, 12'h999);
    chk("pre_wrap_b_ovf", b_ovf, 1'b0);
    step(1);
    chk("wrap_a_bcd", {a2, a1, a0}, 12'h000);
    chk("wrap_a_ovf", a_ovf, 1'b1);
    chk("wrap_a_run", a_run, 1'b1);
    chk("wrap_a_blank", a_blank, 3'b110);
    chk("wrap_c_ovf", c_ovf, 1'b1);
    chk("sat_b_bcd", {b2, b1, b0}, 12'h999);
    chk("sat_b_ovf", b_ovf, 1'b1);
    chk("sat_b_run", b_run, 1'b0);
    step(1);
    chk("post_wrap_a_ovf", a_ovf, 1'b0);
    chk("post_sat_b_ovf", b_ovf, 1'b0);
    chk("post_sat_b_bcd", {b2, b1, b0}, 12'h999);

    // start/stop ignored in OVF; A pauses then resumes
    ss = 1'b1; step(1);
    chk("ovf_ss1_a_run", a_run, 1'b0);
    chk("ovf_ss1_b_run", b_run, 1'b0);
    ss = 1'b0; step(1);
    ss = 1'b1; step(1);
    chk("ovf_ss2_a_run", a_run, 1'b1);
    chk("ovf_ss2_b_run", b_run, 1'b0);
    chk("ovf_ss2_b_bcd", {b2, b1, b0}, 12'h999);
    ss = 1'b0; step(1);

    // clear exits OVF to IDLE; a fresh start counts from a zeroed prescaler
    clr = 1'b1; step(1);
    chk("clr_b_bcd", {b2, b1, b0}, 12'h000);
    chk("clr_b_run", b_run, 1'b0);
    clr = 1'b0; step(1);
    ss = 1'b1; step(1);
    chk("restart_b_run", b_run, 1'b1);
    ss = 1'b0; step(3);
    chk("restart_b_bcd3", {b2, b1, b0}, 12'h000);
    step(1);
    chk("restart_b_bcd4", {b2, b1, b0}, 12'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
